rocc_cmd_arbiter: RTL and testbench

ROCC_CMD_ARBITER -- requirements
Module: rocc_cmd_arbiter

---
 rtl/rocc_cmd_arbiter.sv | 142 ++++++++++++++
 tb/tb_rocc_cmd_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rocc_cmd_arbiter.sv
// Round-robin arbiter that merges several RoCC command sources onto one accelerator
// and routes in-order accelerator responses back to the issuing source.
module rocc_cmd_arbiter #(
  parameter int xLen  = 64,
  parameter int NREQ  = 2,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           in_cmd_valid,
  output logic [NREQ-1:0]           in_cmd_ready,
  input  logic [7*NREQ-1:0]         in_cmd_funct,
  input  logic [5*NREQ-1:0]         in_cmd_rd,
  input  logic [NREQ-1:0]           in_cmd_xd,
  input  logic [xLen*NREQ-1:0]      in_cmd_rs1,
  input  logic [xLen*NREQ-1:0]      in_cmd_rs2,
  output logic                      out_cmd_valid,
  input  logic                      out_cmd_ready,
  output logic [6:0]                out_cmd_funct,
  output logic [4:0]                out_cmd_rd,
  output logic                      out_cmd_xd,
  output logic [xLen-1:0]           out_cmd_rs1,
  output logic [xLen-1:0]           out_cmd_rs2,
  input  logic                      acc_resp_valid,
  output logic                      acc_resp_ready,
  input  logic [4:0]                acc_resp_rd,
  input  logic [xLen-1:0]           acc_resp_data,
  output logic [NREQ-1:0]           in_resp_valid,
  input  logic [NREQ-1:0]           in_resp_ready,
  output logic [4:0]                in_resp_rd,
  output logic [xLen-1:0]           in_resp_data,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      spurious_resp
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          spurious_q;
  logic [IW-1:0] fifo_mem_q [DEPTH];

  logic [IW-1:0] grant_s, head_s;
  logic any_valid_s, full_s, empty_s, cmd_ok_s, cmd_fire_s, push_s, pop_s;

  assign any_valid_s = |in_cmd_valid;
  assign full_s      = (count_q == CW'(DEPTH));
  assign empty_s     = (count_q == '0);
  assign head_s      = fifo_mem_q[rd_ptr_q];
  // Commands are suppressed while reset is held so nothing is handed to the accelerator.
  assign cmd_ok_s    = any_valid_s & ~full_s & ~reset;
  assign cmd_fire_s  = cmd_ok_s & out_cmd_ready;
  assign push_s      = cmd_fire_s & in_cmd_xd[grant_s];
  assign pop_s       = ~empty_s & acc_resp_valid & acc_resp_ready;

  // Round-robin scan: first valid source at or after rr_ptr_q, wrapping modulo NREQ.
  always_comb begin
    logic found;
    int   idx;
    grant_s = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && in_cmd_valid[idx]) begin
        grant_s = IW'(idx);
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  end

  assign out_cmd_valid = cmd_ok_s;
  assign out_cmd_funct = in_cmd_funct[int'(grant_s)*7 +: 7];
  assign out_cmd_rd    = in_cmd_rd[int'(grant_s)*5 +: 5];
  assign out_cmd_xd    = in_cmd_xd[grant_s];
  assign out_cmd_rs1   = in_cmd_rs1[int'(grant_s)*xLen +: xLen];
  assign out_cmd_rs2   = in_cmd_rs2[int'(grant_s)*xLen +: xLen];

  // Only the granted source sees ready.
  always_comb begin
    in_cmd_ready = '0;
    if (cmd_ok_s) begin
      in_cmd_ready[grant_s] = out_cmd_ready;
    end else begin
      in_cmd_ready = '0;
    end
  end

  // Response steering: the FIFO head names the destination; with nothing tracked, drop it.
  always_comb begin
    in_resp_valid = '0;
    if (empty_s) begin
      acc_resp_ready = 1'b1;
    end else begin
      acc_resp_ready        = in_resp_ready[head_s];
      in_resp_valid[head_s] = acc_resp_valid;
    end
  end

  assign in_resp_rd   = acc_resp_rd;
  assign in_resp_data = acc_resp_data;

  // Next-state for pointer and occupancy.
  always_comb begin
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
    rr_ptr_d = cmd_fire_s ? IW'((int'(grant_s) + 1) % NREQ) : rr_ptr_q;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_q + PW'(push_s);
      rd_ptr_q   <= rd_ptr_q + PW'(pop_s);
      count_q    <= count_d;
      spurious_q <= spurious_q | (empty_s & acc_resp_valid);
    end
  end

  // Source-index storage; contents are don't-care outside the valid window.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= grant_s;
    end
  end

  assign busy          = (count_q != '0) | any_valid_s;
  assign outstanding   = count_q;
  assign spurious_resp = spurious_q;

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Bench for rocc_cmd_arbiter: directed vector table, async-reset corner, then random
// traffic checked against a queue-based reference model.
module tb_rocc_cmd_arbiter;

  localparam int XLEN  = 64;
  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        in_cmd_valid, in_cmd_ready, in_cmd_xd;
  logic [7*NREQ-1:0]      in_cmd_funct;
  logic [5*NREQ-1:0]      in_cmd_rd;
  logic [XLEN*NREQ-1:0]   in_cmd_rs1, in_cmd_rs2;
  logic                   out_cmd_valid, out_cmd_ready, out_cmd_xd;
  logic [6:0]             out_cmd_funct;
  logic [4:0]             out_cmd_rd;
  logic [XLEN-1:0]        out_cmd_rs1, out_cmd_rs2;
  logic                   acc_resp_valid, acc_resp_ready;
  logic [4:0]             acc_resp_rd, in_resp_rd;
  logic [XLEN-1:0]        acc_resp_data, in_resp_data;
  logic [NREQ-1:0]        in_resp_valid, in_resp_ready;
  logic                   busy, spurious_resp;
  logic [CW-1:0]          outstanding;

  rocc_cmd_arbiter #(.xLen(XLEN), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_cmd_valid(in_cmd_valid), .in_cmd_ready(in_cmd_ready),
    .in_cmd_funct(in_cmd_funct), .in_cmd_rd(in_cmd_rd), .in_cmd_xd(in_cmd_xd),
    .in_cmd_rs1(in_cmd_rs1), .in_cmd_rs2(in_cmd_rs2),
    .out_cmd_valid(out_cmd_valid), .out_cmd_ready(out_cmd_ready),
    .out_cmd_funct(out_cmd_funct), .out_cmd_rd(out_cmd_rd), .out_cmd_xd(out_cmd_xd),
    .out_cmd_rs1(out_cmd_rs1), .out_cmd_rs2(out_cmd_rs2),
    .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
    .acc_resp_rd(acc_resp_rd), .acc_resp_data(acc_resp_data),
    .in_resp_valid(in_resp_valid), .in_resp_ready(in_resp_ready),
    .in_resp_rd(in_resp_rd), .in_resp_data(in_resp_data),
    .busy(busy), .outstanding(outstanding), .spurious_resp(spurious_resp)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO of issuing sources, round-robin pointer, sticky error.
  int m_q[$];
  int m_rr;
  bit m_sp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_rr = 0;
    m_sp = 1'b0;
  endtask

  function automatic int model_grant();
    int g = 0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (in_cmd_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    return g;
  endfunction

  task automatic model_check();
    int g;
    bit any, full, e_ov, e_arr;
    logic [NREQ-1:0] e_icr, e_irv;
    g     = model_grant();
    any   = (in_cmd_valid != 0);
    full  = (m_q.size() == DEPTH);
    e_ov  = any && !full && !reset;
    e_icr = (e_ov && out_cmd_ready) ? NREQ'(1 << g) : '0;
    if (m_q.size() == 0) begin
      e_arr = 1'b1;
      e_irv = '0;
    end else begin
      e_arr = in_resp_ready[m_q[0]];
      e_irv = acc_resp_valid ? NREQ'(1 << m_q[0]) : '0;
    end
    chk("out_cmd_valid", 64'(out_cmd_valid), 64'(e_ov));
    chk("in_cmd_ready", 64'(in_cmd_ready), 64'(e_icr));
    chk("in_resp_valid", 64'(in_resp_valid), 64'(e_irv));
    chk("acc_resp_ready", 64'(acc_resp_ready), 64'(e_arr));
    chk("outstanding", 64'(outstanding), 64'(m_q.size()));
    chk("busy", 64'(busy), 64'((m_q.size() != 0) || any));
    chk("spurious_resp", 64'(spurious_resp), 64'(m_sp));
    chk("in_resp_rd", 64'(in_resp_rd), 64'(acc_resp_rd));
    chk("in_resp_data", in_resp_data, acc_resp_data);
    if (e_ov) begin
      chk("out_cmd_funct", 64'(out_cmd_funct), 64'(in_cmd_funct[g*7 +: 7]));
      chk("out_cmd_rd", 64'(out_cmd_rd), 64'(in_cmd_rd[g*5 +: 5]));
      chk("out_cmd_xd", 64'(out_cmd_xd), 64'(in_cmd_xd[g]));
      chk("out_cmd_rs1", out_cmd_rs1, in_cmd_rs1[g*XLEN +: XLEN]);
      chk("out_cmd_rs2", out_cmd_rs2, in_cmd_rs2[g*XLEN +: XLEN]);
    end
  endtask

  task automatic model_update();
    int g;
    bit fire, pop;
    if (reset) begin
      model_clear();
    end else begin
      g    = model_grant();
      fire = (in_cmd_valid != 0) && (m_q.size() < DEPTH) && out_cmd_ready;
      pop  = (m_q.size() > 0) && acc_resp_valid && in_resp_ready[m_q[0]];
      if (m_q.size() == 0 && acc_resp_valid) m_sp = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (fire && in_cmd_xd[g]) m_q.push_back(g);
      if (fire) m_rr = (g + 1) % NREQ;
    end
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  typedef struct {
    logic [1:0] cv; logic [1:0] xd; logic ocr; logic av; logic [4:0] ard; logic [1:0] rrdy;
    logic e_ov; logic [1:0] e_icr; logic [1:0] e_irv; logic e_arr; logic [2:0] e_out;
    logic e_sp; logic [6:0] e_funct;
  } vec_t;

  vec_t vecs[23];
  localparam logic [6:0] F0 = 7'h10;
  localparam logic [6:0] F1 = 7'h21;

  initial begin
    // alternation with xd=0
    vecs[0]  = '{2'b11, 2'b00, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 3'd0, 1'b0, F0};
    vecs[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 3'd0, 1'b0, F1};
    vecs[2]  = vecs[0];
    vecs[3]  = vecs[1];
    // in-order routing: src1 rd=5, then src0 rd=7
    vecs[4]  = '{2'b10, 2'b10, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 3'd0, 1'b0, F1};
    vecs[5]  = '{2'b01, 2'b01, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 3'd1, 1'b0, F0};
    vecs[6]  = '{2'b00, 2'b00, 1'b1, 1'b1, 5'd5, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 3'd2, 1'b0, F0};
    vecs[7]  = '{2'b00, 2'b00, 1'b1, 1'b1, 5'd7, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 3'd1, 1'b0, F0};
    vecs[8]  = '{2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0, F0};
    // spurious response on empty FIFO
    vecs[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 5'd3, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0, F0};
    vecs[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b1, F0};
    // fill to DEPTH, then full blocks even with a concurrent pop
    vecs[11] = '{2'b11, 2'b11, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 3'd0, 1'b1, F1};
    vecs[12] = '{2'b11, 2'b11, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 3'd1, 1'b1, F0};
    vecs[13] = '{2'b11, 2'b11, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 3'd2, 1'b1, F1};
    vecs[14] = '{2'b11, 2'b11, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 3'd3, 1'b1, F0};
    vecs[15] = '{2'b11, 2'b11, 1'b1, 1'b0, 5'd0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 3'd4, 1'b1, F0};
    vecs[16] = '{2'b11, 2'b11, 1'b1, 1'b1, 5'd5, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 3'd4, 1'b1, F0};
    vecs[17] = '{2'b11, 2'b11, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 3'd3, 1'b1, F1};
    // head source (0) stalls three cycles
    vecs[18] = '{2'b00, 2'b00, 1'b1, 1'b1, 5'd7, 2'b10, 1'b0, 2'b00, 2'b01, 1'b0, 3'd4, 1'b1, F0};
    vecs[19] = vecs[18];
    vecs[20] = vecs[18];
    vecs[21] = '{2'b00, 2'b00, 1'b1, 1'b1, 5'd7, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 3'd4, 1'b1, F0};
    vecs[22] = '{2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 3'd3, 1'b1, F0};

    model_clear();
    reset          = 1'b1;
    in_cmd_valid   = 2'b11;
    in_cmd_xd      = 2'b11;
    in_cmd_funct   = {F1, F0};
    in_cmd_rd      = {5'd5, 5'd7};
    in_cmd_rs1     = {64'h0000_00B1, 64'h0000_00A1};
    in_cmd_rs2     = {64'h0000_00B2, 64'h0000_00A2};
    out_cmd_ready  = 1'b1;
    acc_resp_valid = 1'b1;
    acc_resp_rd    = 5'd0;
    acc_resp_data  = 64'd0;
    in_resp_ready  = 2'b11;
    // Outputs held quiet during reset even with every input asserted.
    #1 model_check();
    advance();
    model_check();
    advance();
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      in_cmd_valid   = vecs[i].cv;
      in_cmd_xd      = vecs[i].xd;
      out_cmd_ready  = vecs[i].ocr;
      acc_resp_valid = vecs[i].av;
      acc_resp_rd    = vecs[i].ard;
      acc_resp_data  = (vecs[i].ard == 5'd5) ? 64'h11 : 64'h22;
      in_resp_ready  = vecs[i].rrdy;
      #1;
      chk($sformatf("vec%0d.out_cmd_valid", i), 64'(out_cmd_valid), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d.in_cmd_ready", i), 64'(in_cmd_ready), 64'(vecs[i].e_icr));
      chk($sformatf("vec%0d.in_resp_valid", i), 64'(in_resp_valid), 64'(vecs[i].e_irv));
      chk($sformatf("vec%0d.acc_resp_ready", i), 64'(acc_resp_ready), 64'(vecs[i].e_arr));
      chk($sformatf("vec%0d.outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
      chk($sformatf("vec%0d.spurious", i), 64'(spurious_resp), 64'(vecs[i].e_sp));
      if (vecs[i].e_ov) chk($sformatf("vec%0d.funct", i), 64'(out_cmd_funct), 64'(vecs[i].e_funct));
      if (vecs[i].av) chk($sformatf("vec%0d.resp_data", i), in_resp_data, acc_resp_data);
      model_check();
      advance();
    end

    // Async reset mid-cycle with three responses outstanding and spurious set.
    chk("pre_reset.outstanding", 64'(outstanding), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("async_reset.outstanding", 64'(outstanding), 64'd0);
    chk("async_reset.spurious", 64'(spurious_resp), 64'd0);
    chk("async_reset.acc_resp_ready", 64'(acc_resp_ready), 64'd1);
    model_clear();
    advance();
    reset = 1'b0;
    in_cmd_valid = 2'b11;
    in_cmd_xd    = 2'b00;
    #1;
    chk("post_reset.grant0", 64'(in_cmd_ready), 64'b01);
    model_check();
    advance();

    // Random traffic against the reference model, with occasional async resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1 model_clear();
        model_check();
        advance();
        reset = 1'b0;
      end
      in_cmd_valid   = NREQ'($urandom);
      in_cmd_xd      = NREQ'($urandom);
      in_cmd_funct   = (7*NREQ)'($urandom);
      in_cmd_rd      = (5*NREQ)'($urandom);
      in_cmd_rs1     = {$urandom, $urandom, $urandom, $urandom};
      in_cmd_rs2     = {$urandom, $urandom, $urandom, $urandom};
      out_cmd_ready  = ($urandom_range(0, 3) != 0);
      acc_resp_valid = ($urandom_range(0, 9) < 4);
      acc_resp_rd    = 5'($urandom);
      acc_resp_data  = {$urandom, $urandom};
      in_resp_ready  = NREQ'($urandom) | NREQ'($urandom);
      #1 model_check();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
